// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared widths, response codes, FSM state encodings and the
//               port-select type for the two-master AXI4-Lite arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

    localparam int         c_addr_width  = 32;
    localparam int         c_data_width  = 32;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // s0 = core bus, s1 = debug system-bus access
    typedef enum logic {
        PORT_S0 = 1'b0,
        PORT_S1 = 1'b1
    } port_sel_t;

endpackage
`default_nettype wire

// File: rtl/axi4lite_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way picker. Round-robin on a registered last-grant
//               pointer, or s1-wins-ties when FIXED_PRIORITY is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import axi4lite_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  port_sel_t  i_upd_port,
    output port_sel_t  o_pick
);

    port_sel_t r_last;

    // Last-grant pointer; starts as "s1 last" so s0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_S1;
        end else if (i_upd) begin
            r_last <= i_upd_port;
        end
    end

    // Pick a winner from the current requests and the pointer
    always_comb begin
        o_pick = PORT_S0;
        if (i_req == 2'b10) begin
            o_pick = PORT_S1;
        end else if (i_req == 2'b11) begin
            if (FIXED_PRIORITY || (r_last == PORT_S0)) begin
                o_pick = PORT_S1;
            end else begin
                o_pick = PORT_S0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_bus_arbiter
// Description : Shares one AXI4-Lite memory port between the core bus (s0)
//               and the debug SBA path (s1). Independent read and write
//               arbitration, one outstanding transaction per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_bus_arbiter
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // s0 (core)
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [2:0]              s0_awprot,
    input  logic [3:0]              s0_awcache,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    output logic [1:0]              s0_bresp,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [2:0]              s0_arprot,
    input  logic [3:0]              s0_arcache,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [1:0]              s0_rresp,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    // s1 (debug SBA)
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [2:0]              s1_awprot,
    input  logic [3:0]              s1_awcache,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    output logic [1:0]              s1_bresp,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [2:0]              s1_arprot,
    input  logic [3:0]              s1_arcache,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [1:0]              s1_rresp,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    // memory side
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic [3:0]              m_awcache,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic [3:0]              m_arcache,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [1:0]              m_rresp,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    // ---------------------------------------------------------------- read
    rd_state_t r_rd_state;
    port_sel_t r_rd_gnt;
    port_sel_t w_rd_pick;
    logic      w_rd_s1, w_rd_addr_ph, w_rd_data_ph, w_r_hs;

    assign w_rd_s1      = (r_rd_gnt == PORT_S1);
    assign w_rd_addr_ph = (r_rd_state == R_ADDR);
    assign w_rd_data_ph = (r_rd_state == R_DATA);
    assign w_r_hs       = w_rd_data_ph && m_rvalid && m_rready;

    rr_arb2 #(.FIXED_PRIORITY(FIXED_PRIORITY != 0)) u_rd_arb (
        .clk        (aclk),
        .rst_n      (aresetn),
        .i_req      ({s1_arvalid, s0_arvalid}),
        .i_upd      (w_r_hs),
        .i_upd_port (r_rd_gnt),
        .o_pick     (w_rd_pick)
    );

    // Read FSM: grant in IDLE, hold it through the address and data phases
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_rd_gnt   <= PORT_S0;
        end else begin
            case (r_rd_state)
                R_IDLE: if (s0_arvalid || s1_arvalid) begin
                    r_rd_gnt   <= w_rd_pick;
                    r_rd_state <= R_ADDR;
                end
                R_ADDR: if (m_arready) r_rd_state <= R_DATA;
                R_DATA: if (w_r_hs)    r_rd_state <= R_IDLE;
                default:               r_rd_state <= R_IDLE;
            endcase
        end
    end

    // The granted master holds arvalid until its handshake, so the address
    // phase alone qualifies m_arvalid (no s*_arvalid -> m_arvalid path).
    assign m_arvalid  = w_rd_addr_ph;
    assign m_araddr   = w_rd_s1 ? s1_araddr  : s0_araddr;
    assign m_arprot   = w_rd_s1 ? s1_arprot  : s0_arprot;
    assign m_arcache  = w_rd_s1 ? s1_arcache : s0_arcache;
    assign s0_arready = w_rd_addr_ph && !w_rd_s1 && m_arready;
    assign s1_arready = w_rd_addr_ph &&  w_rd_s1 && m_arready;
    assign m_rready   = w_rd_data_ph && (w_rd_s1 ? s1_rready : s0_rready);
    assign s0_rvalid  = w_rd_data_ph && !w_rd_s1 && m_rvalid;
    assign s1_rvalid  = w_rd_data_ph &&  w_rd_s1 && m_rvalid;
    assign s0_rresp   = (w_rd_data_ph && !w_rd_s1) ? m_rresp : '0;
    assign s1_rresp   = (w_rd_data_ph &&  w_rd_s1) ? m_rresp : '0;
    assign s0_rdata   = (w_rd_data_ph && !w_rd_s1) ? m_rdata : '0;
    assign s1_rdata   = (w_rd_data_ph &&  w_rd_s1) ? m_rdata : '0;

    // --------------------------------------------------------------- write
    wr_state_t r_wr_state;
    port_sel_t r_wr_gnt;
    port_sel_t w_wr_pick;
    logic      r_aw_done, r_w_done, r_w_seen;
    logic      w_wr_s1, w_xfer, w_resp, w_aw_open, w_w_open;
    logic      w_aw_hs, w_w_hs, w_b_hs, w_g_wvalid;

    assign w_wr_s1    = (r_wr_gnt == PORT_S1);
    assign w_xfer     = (r_wr_state == W_XFER);
    assign w_resp     = (r_wr_state == W_RESP);
    assign w_g_wvalid = w_wr_s1 ? s1_wvalid : s0_wvalid;
    assign w_aw_open  = w_xfer && !r_aw_done;
    // wvalid is not implied by the grant, so it is taken from a registered
    // copy to keep s*_wvalid off the combinational path to m_wvalid.
    assign w_w_open   = w_xfer && !r_w_done && r_w_seen;
    assign w_aw_hs    = w_aw_open && m_awready;
    assign w_w_hs     = w_w_open && m_wready;
    assign w_b_hs     = w_resp && m_bvalid && m_bready;

    rr_arb2 #(.FIXED_PRIORITY(FIXED_PRIORITY != 0)) u_wr_arb (
        .clk        (aclk),
        .rst_n      (aresetn),
        .i_req      ({s1_awvalid, s0_awvalid}),
        .i_upd      (w_b_hs),
        .i_upd_port (r_wr_gnt),
        .o_pick     (w_wr_pick)
    );

    // Write FSM: aw and w complete independently, tracked by sticky flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_state <= W_IDLE;
            r_wr_gnt   <= PORT_S0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_w_seen   <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: if (s0_awvalid || s1_awvalid) begin
                    r_wr_gnt   <= w_wr_pick;
                    r_w_seen   <= (w_wr_pick == PORT_S1) ? s1_wvalid : s0_wvalid;
                    r_wr_state <= W_XFER;
                end
                W_XFER: begin
                    r_aw_done <= r_aw_done || w_aw_hs;
                    r_w_done  <= r_w_done || w_w_hs;
                    r_w_seen  <= r_w_seen || w_g_wvalid;
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: if (w_b_hs) begin
                    r_aw_done  <= 1'b0;
                    r_w_done   <= 1'b0;
                    r_w_seen   <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign m_awvalid  = w_aw_open;
    assign m_awaddr   = w_wr_s1 ? s1_awaddr  : s0_awaddr;
    assign m_awprot   = w_wr_s1 ? s1_awprot  : s0_awprot;
    assign m_awcache  = w_wr_s1 ? s1_awcache : s0_awcache;
    assign s0_awready = w_aw_open && !w_wr_s1 && m_awready;
    assign s1_awready = w_aw_open &&  w_wr_s1 && m_awready;
    assign m_wvalid   = w_w_open;
    assign m_wdata    = w_wr_s1 ? s1_wdata : s0_wdata;
    assign m_wstrb    = w_wr_s1 ? s1_wstrb : s0_wstrb;
    assign s0_wready  = w_w_open && !w_wr_s1 && m_wready;
    assign s1_wready  = w_w_open &&  w_wr_s1 && m_wready;
    assign m_bready   = w_resp && (w_wr_s1 ? s1_bready : s0_bready);
    assign s0_bvalid  = w_resp && !w_wr_s1 && m_bvalid;
    assign s1_bvalid  = w_resp &&  w_wr_s1 && m_bvalid;
    assign s0_bresp   = (w_resp && !w_wr_s1) ? m_bresp : '0;
    assign s1_bresp   = (w_resp &&  w_wr_s1) ? m_bresp : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_bus_arbiter
// Description : Self-checking bench: two master drivers, a single-cycle
//               memory model, and expected-response queues per master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_bus_arbiter;

    localparam int FIXED_PRIO = 0;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    // master-side drives
    logic [1:0]  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [31:0] s_araddr [2];
    logic [31:0] s_awaddr [2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic [2:0]  s_prot   [2];
    logic [3:0]  s_cache  [2];

    // DUT outputs
    logic        s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
    logic        s0_arready, s1_arready, s0_rvalid, s1_rvalid;
    logic [1:0]  s0_bresp, s1_bresp, s0_rresp, s1_rresp;
    logic [31:0] s0_rdata, s1_rdata;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_awcache, m_arcache, m_wstrb;

    logic [1:0]  s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0] s_rdata [2];
    logic [1:0]  s_rresp [2];
    logic [1:0]  s_bresp [2];
    assign s_arready  = {s1_arready, s0_arready};
    assign s_rvalid   = {s1_rvalid, s0_rvalid};
    assign s_awready  = {s1_awready, s0_awready};
    assign s_wready   = {s1_wready, s0_wready};
    assign s_bvalid   = {s1_bvalid, s0_bvalid};
    assign s_rdata[0] = s0_rdata;
    assign s_rdata[1] = s1_rdata;
    assign s_rresp[0] = s0_rresp;
    assign s_rresp[1] = s1_rresp;
    assign s_bresp[0] = s0_bresp;
    assign s_bresp[1] = s1_bresp;

    // memory model
    logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    logic        mem_rv, mem_aw_got, mem_w_got, mem_bv;
    logic [31:0] mem_rdata, mem_awaddr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem [0:16383];

    assign m_arready = !mem_rv;
    assign m_rvalid  = mem_rv;
    assign m_rdata   = mem_rdata;
    assign m_rresp   = 2'b00;
    assign m_awready = !mem_aw_got;
    assign m_wready  = !mem_w_got;
    assign m_bvalid  = mem_bv;
    assign m_bresp   = 2'b00;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem_rv <= 1'b0; mem_aw_got <= 1'b0; mem_w_got <= 1'b0; mem_bv <= 1'b0;
            mem_rdata <= '0; mem_awaddr <= '0; mem_wdata <= '0; mem_wstrb <= '0;
            mem[14'h1040] <= 32'hdeadbeef;   // 0x4100
            mem[14'h1C00] <= 32'h11223344;   // 0x7000
            mem[14'h1C01] <= 32'hAABBCCDD;   // 0x7004
        end else begin
            if (m_arvalid && m_arready) begin
                mem_rv    <= 1'b1;
                mem_rdata <= mem[m_araddr[15:2]];
            end else if (mem_rv && m_rready) begin
                mem_rv <= 1'b0;
            end
            if (m_awvalid && m_awready) begin mem_aw_got <= 1'b1; mem_awaddr <= m_awaddr; end
            if (m_wvalid && m_wready) begin
                mem_w_got <= 1'b1; mem_wdata <= m_wdata; mem_wstrb <= m_wstrb;
            end
            if (mem_aw_got && mem_w_got && !mem_bv) begin
                for (int i = 0; i < 4; i++)
                    if (mem_wstrb[i]) mem[mem_awaddr[15:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
                mem_bv <= 1'b1;
            end
            if (mem_bv && m_bready) begin
                mem_bv <= 1'b0; mem_aw_got <= 1'b0; mem_w_got <= 1'b0;
            end
        end
    end

    axi4lite_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(FIXED_PRIO)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_awvalid(s_awvalid[0]), .s0_awready(s0_awready), .s0_awaddr(s_awaddr[0]),
        .s0_awprot(s_prot[0]), .s0_awcache(s_cache[0]),
        .s0_wvalid(s_wvalid[0]), .s0_wready(s0_wready), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
        .s0_bvalid(s0_bvalid), .s0_bready(s_bready[0]), .s0_bresp(s0_bresp),
        .s0_arvalid(s_arvalid[0]), .s0_arready(s0_arready), .s0_araddr(s_araddr[0]),
        .s0_arprot(s_prot[0]), .s0_arcache(s_cache[0]),
        .s0_rvalid(s0_rvalid), .s0_rready(s_rready[0]), .s0_rresp(s0_rresp), .s0_rdata(s0_rdata),
        .s1_awvalid(s_awvalid[1]), .s1_awready(s1_awready), .s1_awaddr(s_awaddr[1]),
        .s1_awprot(s_prot[1]), .s1_awcache(s_cache[1]),
        .s1_wvalid(s_wvalid[1]), .s1_wready(s1_wready), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
        .s1_bvalid(s1_bvalid), .s1_bready(s_bready[1]), .s1_bresp(s1_bresp),
        .s1_arvalid(s_arvalid[1]), .s1_arready(s1_arready), .s1_araddr(s_araddr[1]),
        .s1_arprot(s_prot[1]), .s1_arcache(s_cache[1]),
        .s1_rvalid(s1_rvalid), .s1_rready(s_rready[1]), .s1_rresp(s1_rresp), .s1_rdata(s1_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awprot(m_awprot), .m_awcache(m_awcache),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arprot(m_arprot), .m_arcache(m_arcache),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata)
    );

    // checking
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // scoreboard
    logic [31:0] exp_rd0 [$];
    logic [31:0] exp_rd1 [$];
    logic [1:0]  exp_b0  [$];
    logic [1:0]  exp_b1  [$];
    int          gnt_log [$];
    int          m_b_cnt = 0;
    time         t_s0_r  = 0;
    time         t_s1_ar = 0;

    function automatic logic [14:0] vr_vec();
        return {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                s_arready, s_rvalid, s_awready, s_wready, s_bvalid};
    endfunction

    always @(negedge aclk) begin
        if (aresetn) begin
            for (int p = 0; p < 2; p++) begin
                if (s_arvalid[p] && s_arready[p]) begin
                    gnt_log.push_back(p);
                    if (p == 1) t_s1_ar = $time;
                end
                if (s_rvalid[p])
                    chk($sformatf("s%0d_rvalid_expected", p),
                        64'((p == 0 ? exp_rd0.size() : exp_rd1.size()) != 0), 64'(1));
                if (s_rvalid[p] && s_rready[p]) begin
                    if (p == 0 && exp_rd0.size() != 0) begin
                        chk("s0_rdata", 64'(s_rdata[0]), 64'(exp_rd0.pop_front()));
                        t_s0_r = $time;
                    end else if (p == 1 && exp_rd1.size() != 0) begin
                        chk("s1_rdata", 64'(s_rdata[1]), 64'(exp_rd1.pop_front()));
                    end
                    chk($sformatf("s%0d_rresp", p), 64'(s_rresp[p]), 64'(0));
                end
                if (s_bvalid[p])
                    chk($sformatf("s%0d_bvalid_expected", p),
                        64'((p == 0 ? exp_b0.size() : exp_b1.size()) != 0), 64'(1));
                if (s_bvalid[p] && s_bready[p]) begin
                    if (p == 0 && exp_b0.size() != 0) chk("s0_bresp", 64'(s_bresp[0]), 64'(exp_b0.pop_front()));
                    else if (p == 1 && exp_b1.size() != 0) chk("s1_bresp", 64'(s_bresp[1]), 64'(exp_b1.pop_front()));
                end
            end
            if (m_bvalid && m_bready) m_b_cnt++;
        end
    end

    task automatic rd(input int p, input logic [31:0] a, input logic [31:0] exp);
        int n;
        if (p == 0) exp_rd0.push_back(exp); else exp_rd1.push_back(exp);
        s_araddr[p] = a; s_arvalid[p] = 1'b1; s_rready[p] = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_arready[p] && n < 200);
        chk($sformatf("s%0d_ar_in_time", p), 64'(s_arready[p]), 64'(1));
        @(posedge aclk); #1 s_arvalid[p] = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_rvalid[p] && n < 200);
        chk($sformatf("s%0d_r_in_time", p), 64'(s_rvalid[p]), 64'(1));
        @(posedge aclk); #1 s_rready[p] = 1'b0;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] strb, input int lead);
        int  n;
        logic aw_h, w_h;
        if (p == 0) exp_b0.push_back(2'b00); else exp_b1.push_back(2'b00);
        s_wdata[p] = d; s_wstrb[p] = strb; s_wvalid[p] = 1'b1; s_bready[p] = 1'b1;
        if (lead > 0) begin
            for (int i = 0; i < lead; i++) begin
                @(negedge aclk);
                chk("w_alone_no_wready", 64'(s_wready[p]), 64'(0));
                chk("w_alone_no_m_wvalid", 64'(m_wvalid), 64'(0));
            end
            @(posedge aclk); #1;
        end
        s_awaddr[p] = a; s_awvalid[p] = 1'b1;
        n = 0;
        while ((s_awvalid[p] || s_wvalid[p]) && n < 200) begin
            @(negedge aclk);
            aw_h = s_awvalid[p] && s_awready[p];
            w_h  = s_wvalid[p] && s_wready[p];
            @(posedge aclk); #1;
            if (aw_h) s_awvalid[p] = 1'b0;
            if (w_h)  s_wvalid[p]  = 1'b0;
            n++;
        end
        chk($sformatf("s%0d_aw_w_in_time", p), 64'({s_awvalid[p], s_wvalid[p]}), 64'(0));
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_bvalid[p] && n < 200);
        chk($sformatf("s%0d_b_in_time", p), 64'(s_bvalid[p]), 64'(1));
        @(posedge aclk); #1 s_bready[p] = 1'b0;
    endtask

    initial begin
        int   last, win, n, b0;
        logic bp_done;
        s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_bready = '0;
        for (int p = 0; p < 2; p++) begin
            s_araddr[p] = '0; s_awaddr[p] = '0; s_wdata[p] = '0; s_wstrb[p] = '0;
            s_prot[p] = '0; s_cache[p] = '0;
        end
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_outputs", 64'(vr_vec()), 64'(0));
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // tie arbitration, starting from the reset pointer
        last = 1;
        for (int r = 0; r < 4; r++) begin
            gnt_log.delete();
            fork
                rd(0, 32'h4100, 32'hdeadbeef);
                rd(1, 32'h4100, 32'hdeadbeef);
            join
            win = (FIXED_PRIO != 0) ? 1 : ((last == 1) ? 0 : 1);
            chk("tie_log_size", 64'(gnt_log.size()), 64'(2));
            if (gnt_log.size() == 2) begin
                chk($sformatf("tie%0d_first", r), 64'(gnt_log.pop_front()), 64'(win));
                chk($sformatf("tie%0d_second", r), 64'(gnt_log.pop_front()), 64'(1 - win));
            end
            last = 1 - win;
        end

        // single read with grant latency and prot pass-through
        s_prot[0] = 3'b101;
        fork
            rd(0, 32'h4100, 32'hdeadbeef);
            begin
                @(negedge aclk);
                chk("m_arvalid_before_grant", 64'(m_arvalid), 64'(0));
                @(negedge aclk);
                chk("m_arvalid_after_grant", 64'(m_arvalid), 64'(1));
                chk("m_arprot_pass", 64'(m_arprot), 64'(3'b101));
            end
        join
        s_prot[0] = 3'b000;

        // write with w leading aw by two cycles
        b0 = m_b_cnt;
        wr(1, 32'h6000, 32'h1, 4'hF, 2);
        chk("single_m_b_hs", 64'(m_b_cnt - b0), 64'(1));
        rd(0, 32'h6000, 32'h1);

        // read and write in flight together
        fork
            rd(0, 32'h7000, 32'h11223344);
            wr(1, 32'h7004, 32'h55667788, 4'h3, 0);
        join
        rd(1, 32'h7004, 32'hAABB7788);

        // backpressure on s0 r while s1 read waits
        t_s0_r = 0; t_s1_ar = 0; bp_done = 1'b0;
        exp_rd0.push_back(32'h1);
        s_araddr[0] = 32'h6000; s_arvalid[0] = 1'b1; s_rready[0] = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_arready[0] && n < 200);
        chk("bp_ar_in_time", 64'(s_arready[0]), 64'(1));
        @(posedge aclk); #1 s_arvalid[0] = 1'b0;
        fork
            begin rd(1, 32'h4100, 32'hdeadbeef); bp_done = 1'b1; end
        join_none
        repeat (5) begin
            @(negedge aclk);
            chk("bp_m_rready_low", 64'(m_rready), 64'(0));
            chk("bp_s1_not_granted", 64'(s_arready[1]), 64'(0));
        end
        @(posedge aclk); #1 s_rready[0] = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_rvalid[0] && n < 200);
        chk("bp_r_in_time", 64'(s_rvalid[0]), 64'(1));
        @(posedge aclk); #1 s_rready[0] = 1'b0;
        n = 0;
        while (!bp_done && n < 400) begin @(posedge aclk); n++; end
        chk("bp_s1_done", 64'(bp_done), 64'(1));
        chk("bp_s1_after_s0", 64'(t_s1_ar > t_s0_r), 64'(1));

        // reset while the write is in W_XFER
        @(posedge aclk); #1;
        s_awaddr[0] = 32'h6000; s_awvalid[0] = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("xfer_m_awvalid", 64'(m_awvalid), 64'(1));
        #2 aresetn = 1'b0;
        #1 chk("async_reset_outputs", 64'(vr_vec()), 64'(0));
        s_awvalid[0] = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        wr(0, 32'h6000, 32'h2, 4'hF, 0);
        rd(0, 32'h6000, 32'h2);

        repeat (5) @(posedge aclk);
        chk("rd0_q_empty", 64'(exp_rd0.size()), 64'(0));
        chk("rd1_q_empty", 64'(exp_rd1.size()), 64'(0));
        chk("b_q_empty", 64'(exp_b0.size() + exp_b1.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4lite_bus_arbiter.md
# axi4lite_bus_arbiter

Two-master, one-slave AXI4-Lite arbiter that shares the single memory port (MockAXI4LiteSRAM or the real SRAM controller) between the BottleRocket core bus and the debug-module system bus access (SBA) path. Read and write channels are arbitrated independently, round-robin by default. Each channel allows one outstanding transaction. Responses route back only to the granted master.

## Interface
Parameters:
- ADDR_WIDTH, 32: address width on all ports.
- DATA_WIDTH, 32: data width; strobe width is DATA_WIDTH/8.
- FIXED_PRIORITY, 0: 0 selects round-robin; 1 means s1 (debug) always wins a tie.

Ports. Each `{s0,s1}_` line is instantiated once per slave port; s0 = core, s1 = SBA.
- aclk  in  1  sole clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- {s0,s1}_awvalid/awready/awaddr/awprot/awcache  in/out/in/in/in  1/1/ADDR_WIDTH/3/4  write-address channel from master.
- {s0,s1}_wvalid/wready/wdata/wstrb  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8  write-data channel.
- {s0,s1}_bvalid/bready/bresp  out/in/out  1/1/2  write response.
- {s0,s1}_arvalid/arready/araddr/arprot/arcache  in/out/in/in/in  1/1/ADDR_WIDTH/3/4  read address.
- {s0,s1}_rvalid/rready/rresp/rdata  out/in/out/out  1/1/2/DATA_WIDTH  read response.
- m_aw*/m_w*/m_b*/m_ar*/m_r*: the same signal set with directions mirrored, connected to the memory.

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any s*_arvalid is high, register the grant (rd_gnt) and go to R_ADDR.
  - R_ADDR: m_ar* is driven from the granted port; granted arready = m_arready. On the m_ar handshake, go to R_DATA.
  - R_DATA: m_r* routes to the granted port; m_rready = granted rready. On the m_r handshake, update the RR pointer and return to R_IDLE.
- Write FSM states: W_IDLE, W_XFER, W_RESP.
  - W_IDLE: only s*_awvalid requests a grant; wvalid alone never requests.
  - W_XFER: m_aw and m_w are forwarded from the granted port independently. Sticky flags aw_done and w_done record each handshake, and each channel's valid/ready is masked once its flag is set. When both flags are set (including in the same cycle), go to W_RESP.
  - W_RESP: route b to the granted port. On the handshake, update the pointer, clear the flags and return to W_IDLE.
- Arbitration (sub-module rr_arb2):
  - With a single requester, that requester wins.
  - With both requesting: if FIXED_PRIORITY is 1, s1 wins; otherwise the port not granted last wins. The pointer resets to "s1 last", so s0 wins the first tie.
  - Read and write pointers are separate.
- A non-granted port sees all its ready and valid outputs at 0, and all its data outputs at 0.
- prot, cache, strb and resp pass through unmodified. The arbiter never generates error responses.
- A read and a write may be in flight simultaneously, to the same or different masters.

## Timing
- Reset: every s*_*ready, s*_bvalid, s*_rvalid, m_*valid and m_*ready output is 0. Both FSMs are IDLE and the flags are cleared. Reset is asynchronous: an in-flight transaction is abandoned immediately and the memory must be reset alongside.
- Grant latency: a request is sampled at edge N; m_arvalid/m_awvalid is high from N+1.
- ready/valid and data muxing is combinational from the registered grant and state. There is no combinational path from any s*_valid to any m_*valid.
- Throughput: a read costs at least 3 cycles (IDLE, ADDR, DATA with single-cycle memory). The next grant is earliest the cycle after the r handshake.
- The granted master must hold valid and payload stable until its handshake, per AXI. The arbiter does not re-sample the grant mid-transaction.
- A request arriving while its channel is busy waits; its ready stays 0.

## Structure
- axi4lite_pkg holds: width constants, resp codes (OKAY=0, SLVERR=2), rd_state_t and wr_state_t enums, and the port-select typedef.
- Sub-module rr_arb2: 2-way round-robin/fixed picker with a registered last-grant pointer. It is instantiated once for read and once for write, with an update strobe taken from the response handshake.

## Test plan
- Single read: s0 reads 0x4100 holding 0xdeadbeef. Expect m_arvalid at cycle+1, s0_rdata=0xdeadbeef with rresp=0, and s1_rvalid never high.
- Tie: s0 and s1 both assert arvalid in the same cycle, repeated 4 times. With FIXED_PRIORITY=0, grants go s0, s1, s0, s1. With FIXED_PRIORITY=1, every grant goes to s1.
- Write ordering: s1 presents w two cycles before aw to address 0x6000 with data 1. Expect a single m_b handshake, and a later read of 0x6000 returns 1.
- Concurrency: an s0 read of 0x7000 overlaps an s1 write of 0x7004 with strb=0x3. Both complete, and the bytes of 0x7004 outside strb are unchanged.
- Backpressure: hold s0_rready=0 for 5 cycles during R_DATA. m_rready stays 0, and a pending s1 arvalid is not granted until the s0 r handshake completes.
- Reset mid-write: drop aresetn while in W_XFER. All valid/ready outputs go to 0 asynchronously, and after release a new s0 write completes normally.
